// File: rtl/ksa_seq_divider.sv
// ---------------------------------------------------------------------------
// ksa_seq_divider
//
// Sequential restoring divider: the divide path next to the Wallace /
// Kogge-Stone multiplier. One quotient bit is produced per clock. Each
// iteration does one trial subtraction R - divisor, built as a + ~b + 1 on a
// (WIDTH+1)-bit Kogge-Stone parallel-prefix adder.
//
// Optional feature (compile-time macro DIV_SIGNED_EN):
//   undefined : unsigned operands and results, no negation logic.
//   defined   : two's-complement operands. Magnitudes are taken at capture,
//               the unsigned core runs with the same latency, and results are
//               sign-corrected when they are committed (quotient truncates
//               toward zero, remainder takes the dividend's sign).
//
// Parameters:
//   WIDTH       operand, quotient and remainder width (>= 2)
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   start        in   request pulse, accepted only in IDLE
//   dividend     in   numerator, captured on accepted start
//   divisor      in   denominator, captured on accepted start
//   busy         out  high from the edge after an accepted start until DONE
//   done         out  one-cycle pulse, results valid
//   quotient     out  registered quotient
//   remainder    out  registered remainder
//   div_by_zero  out  registered flag: captured divisor was zero
//
// Handshake: start is a request that is accepted on a rising edge only when
// the FSM is in IDLE; anything presented in RUN/ZERO/FINISH/DONE is dropped.
// done is a single-cycle pulse during which quotient/remainder/div_by_zero
// are valid; they keep that value until the next completed operation.
//
// FSM walk (start edge = E0):
//   IDLE -E0-> RUN -E1..E(WIDTH)-> FINISH -E(WIDTH+1)-> DONE -> IDLE
//   IDLE -E0-> ZERO -E1-> FINISH -E2-> DONE -> IDLE
// FINISH is the commit step: the result registers are loaded on the edge
// that leaves it, so they change together with done rising. The current
// state is visible as state_q for debug.
// ---------------------------------------------------------------------------
module ksa_seq_divider #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int N      = WIDTH + 1;          // subtractor width
    localparam int STAGES = $clog2(N);          // prefix stages
    localparam int CW     = $clog2(WIDTH);      // iteration counter width

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_ZERO   = 3'd2,
        S_FINISH = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Working registers
    logic [WIDTH:0]   rem_q,  rem_d;    // partial remainder R
    logic [WIDTH-1:0] qsr_q,  qsr_d;    // quotient shift register Q
    logic [WIDTH-1:0] dvsr_q, dvsr_d;   // divisor magnitude
    logic [WIDTH-1:0] dvnd_q, dvnd_d;   // dividend as presented (zero case)
    logic [CW-1:0]    cnt_q,  cnt_d;    // iterations remaining - 1
    logic             zero_q, zero_d;   // captured divisor was zero
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;

    // Result registers
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q,       dbz_d;

    // -----------------------------------------------------------------------
    // Operand conditioning at capture
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic             dividend_neg;
    logic             divisor_neg;

`ifdef DIV_SIGNED_EN
    assign dividend_neg = dividend[WIDTH-1];
    assign divisor_neg  = divisor[WIDTH-1];
    // The most-negative value maps onto itself, which read as unsigned is
    // exactly its magnitude, so the core needs no special case.
    assign dividend_mag = dividend_neg ? (~dividend + 1'b1) : dividend;
    assign divisor_mag  = divisor_neg  ? (~divisor  + 1'b1) : divisor;
`else
    assign dividend_neg = 1'b0;
    assign divisor_neg  = 1'b0;
    assign dividend_mag = dividend;
    assign divisor_mag  = divisor;
`endif

    // -----------------------------------------------------------------------
    // Kogge-Stone subtractor: ks_diff = ks_a - {0,divisor} = ks_a + ~b + 1
    // -----------------------------------------------------------------------
    logic [N-1:0] ks_a;       // shifted partial remainder {R, Q msb}
    logic [N-1:0] ks_b;       // inverted divisor
    logic [N-1:0] ks_hp;      // half-sum (bitwise propagate)
    logic [N-1:0] ks_carry;   // carry into each bit
    logic [N-1:0] ks_diff;
    logic         ks_cout;
    logic         borrow;

    logic [STAGES:0][N-1:0]   ks_g;   // group generate per stage
    logic [STAGES-1:0][N-1:0] ks_p;   // group propagate per stage

    assign ks_a  = {rem_q[WIDTH-1:0], qsr_q[WIDTH-1]};
    assign ks_b  = ~{1'b0, dvsr_q};
    assign ks_hp = ks_a ^ ks_b;

    // The +1 carry-in is folded into bit 0's generate so that every group
    // generate that reaches bit 0 already accounts for it.
    assign ks_g[0] = (ks_a & ks_b) | {{(N-1){1'b0}}, ks_hp[0]};
    assign ks_p[0] = ks_hp;

    genvar s, i;
    generate
        for (s = 0; s < STAGES; s++) begin : g_stage
            for (i = 0; i < N; i++) begin : g_bit
                if (i >= (1 << s)) begin : g_op
                    assign ks_g[s+1][i] = ks_g[s][i] |
                                          (ks_p[s][i] & ks_g[s][i-(1<<s)]);
                    if (s < STAGES - 1) begin : g_pnext
                        assign ks_p[s+1][i] = ks_p[s][i] & ks_p[s][i-(1<<s)];
                    end
                end else begin : g_pass
                    // This group already spans down to bit 0 (and the
                    // carry-in), so a full propagate implies a generate:
                    // g | p equals g here and just forwards the value.
                    assign ks_g[s+1][i] = ks_g[s][i] | ks_p[s][i];
                    if (s < STAGES - 1) begin : g_pnext
                        assign ks_p[s+1][i] = ks_p[s][i];
                    end
                end
            end
        end
    endgenerate

    assign ks_carry = {ks_g[STAGES][N-2:0], 1'b1};
    assign ks_diff  = ks_hp ^ ks_carry;
    assign ks_cout  = ks_g[STAGES][N-1];
    // A subtraction borrows exactly when the a + ~b + 1 add has no carry-out.
    assign borrow   = ~ks_cout;

    // -----------------------------------------------------------------------
    // Result correction on commit
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

`ifdef DIV_SIGNED_EN
    assign quo_fix = (sign_a_q ^ sign_b_q) ? (~qsr_q + 1'b1) : qsr_q;
    assign rem_fix = sign_a_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
`else
    assign quo_fix = qsr_q;
    assign rem_fix = rem_q[WIDTH-1:0];
`endif

    // -----------------------------------------------------------------------
    // FSM process 1: state and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            qsr_q       <= '0;
            dvsr_q      <= '0;
            dvnd_q      <= '0;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            qsr_q       <= qsr_d;
            dvsr_q      <= dvsr_d;
            dvnd_q      <= dvnd_d;
            cnt_q       <= cnt_d;
            zero_q      <= zero_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (divisor == '0) ? S_ZERO : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    state_d = S_FINISH;
                end
            end
            S_ZERO:   state_d = S_FINISH;
            S_FINISH: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath next values (driven by the current state)
    // -----------------------------------------------------------------------
    always_comb begin
        rem_d       = rem_q;
        qsr_d       = qsr_q;
        dvsr_d      = dvsr_q;
        dvnd_d      = dvnd_q;
        cnt_d       = cnt_q;
        zero_d      = zero_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d    = '0;
                    qsr_d    = dividend_mag;
                    dvsr_d   = divisor_mag;
                    dvnd_d   = dividend;
                    cnt_d    = CW'(WIDTH - 1);
                    zero_d   = (divisor == '0);
                    sign_a_d = dividend_neg;
                    sign_b_d = divisor_neg;
                end
            end
            S_RUN: begin
                // Shift {R,Q} left; keep the trial difference only when it
                // did not borrow, otherwise restore the shifted remainder.
                rem_d = borrow ? ks_a : ks_diff;
                qsr_d = {qsr_q[WIDTH-2:0], ~borrow};
                cnt_d = cnt_q - 1'b1;
            end
            S_FINISH: begin
                if (zero_q) begin
                    quotient_d  = '1;
                    remainder_d = dvnd_q;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = quo_fix;
                    remainder_d = rem_fix;
                    dbz_d       = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_RUN, S_ZERO, S_FINISH: busy = 1'b1;
            S_DONE:                  done = 1'b1;
            default: begin
            end
        endcase
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_ksa_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_ksa_seq_divider
//
// Directed bench for ksa_seq_divider (WIDTH = 5). The driver issues start
// pulses and pushes the hand-computed result plus the cycle on which done
// must appear; an independent monitor pops and compares on every done.
// ---------------------------------------------------------------------------
module tb_ksa_seq_divider;

    localparam int W = 5;

    // clock / reset
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ksa_seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // scoreboard
    logic [2*W:0] exp_q[$];   // {quotient, remainder, div_by_zero}
    int           due_q[$];   // cycle count at which done must be seen
    int           total = 0;
    int           bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // monitor
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (done) begin
            check("done_pulse_width", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)",
                         cyc);
            end else begin
                logic [2*W:0] e;
                int           d;
                e = exp_q.pop_front();
                d = due_q.pop_front();
                check("quotient",    32'(quotient),    32'(e[2*W:W+1]));
                check("remainder",   32'(remainder),   32'(e[W:1]));
                check("div_by_zero", 32'(div_by_zero), 32'(e[0]));
                check("done_latency", cyc, d);
            end
        end
        prev_done = done;
    end

    // driver: one accepted start, returns #1 after the start edge
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom_range(0, (1 << W) - 1));
        divisor  = W'($urandom_range(0, (1 << W) - 1));
        exp_q.push_back({eq, er, ez});
        due_q.push_back(cyc + ((b == '0) ? 2 : W + 1));
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles");
            exp_q.delete();
            due_q.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      {31'd0, busy},        32'd0);
        check({tag, "_done"},      {31'd0, done},        32'd0);
        check({tag, "_quotient"},  32'(quotient),        32'd0);
        check({tag, "_remainder"}, 32'(remainder),       32'd0);
        check({tag, "_dbz"},       {31'd0, div_by_zero}, 32'd0);
    endtask

    initial begin
        // reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

`ifdef DIV_SIGNED_EN
        // -13 / 4 -> -3 rem -1
        issue(5'b10011, 5'd4, 5'b11101, 5'b11111, 1'b0);
        wait_done();
        // -16 / -1 -> -16 rem 0 (overflow, no flag)
        issue(5'b10000, 5'b11111, 5'b10000, 5'd0, 1'b0);
        wait_done();
        // 7 / -2 -> -3 rem 1
        issue(5'd7, 5'b11110, 5'b11101, 5'd1, 1'b0);
        wait_done();
        // 7 / 0 -> -1 rem 7, flag
        issue(5'd7, 5'd0, 5'b11111, 5'd7, 1'b1);
        wait_done();
        issue(5'd10, 5'd3, 5'd3, 5'd1, 1'b0);
        wait_done();
`else
        // basic cases
        issue(5'd29, 5'd5, 5'd5, 5'd4, 1'b0);
        wait_done();
        @(negedge clk);
        check("busy_idle", {31'd0, busy}, 32'd0);
        issue(5'd31, 5'd1, 5'd31, 5'd0, 1'b0);
        wait_done();
        issue(5'd3, 5'd9, 5'd0, 5'd3, 1'b0);
        wait_done();
        // divide by zero, then a normal op clears the flag
        issue(5'd7, 5'd0, 5'd31, 5'd7, 1'b1);
        wait_done();
        issue(5'd10, 5'd3, 5'd3, 5'd1, 1'b0);
        wait_done();
`endif

        // start re-pulsed in the third RUN cycle is ignored; results hold
        issue(5'd29, 5'd5, 5'd5, 5'd4, 1'b0);
        @(negedge clk);
        check("hold_quotient_run1",  32'(quotient),  32'd3);
        @(negedge clk);
        check("hold_remainder_run2", 32'(remainder), 32'd1);
        @(negedge clk);
        start    = 1'b1;
        dividend = 5'd20;
        divisor  = 5'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("hold_quotient_run4", 32'(quotient),   32'd3);
        check("hold_dbz_run4",      {31'd0, div_by_zero}, 32'd0);
        wait_done();
        repeat (10) @(negedge clk);

        // reset in the second RUN cycle: outputs clear, no done
        @(negedge clk);
        start    = 1'b1;
        dividend = 5'd29;
        divisor  = 5'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midrun_reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        issue(5'd12, 5'd5, 5'd2, 5'd2, 1'b0);
        wait_done();
        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
